// File: rtl/btn_pkg.sv
// Shared types and elaboration-time helpers for the button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    // Ceiling log2; clog2(1) is 0, so callers clamp with max2 when a width is needed.
    function automatic int clog2(input int value);
        int v;
        int w;
        v = value - 1;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, and auto-repeat FSM.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | button released (or repeat disabled and not yet pressed)
// ST_DELAY  | pressed, timer counting down the initial repeat delay
// ST_REPEAT | held past the delay, timer counting down each repeat period
module btn_channel
    import btn_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_press_nxt,
    output logic o_repeat_nxt
);

    localparam int CNT_W = max2(1, clog2(DEBOUNCE_CYCLES));
    localparam int TMR_W = max2(1, clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1));

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_repeat;
    logic [TMR_W-1:0] r_timer;
    rpt_state_t       r_state;

    logic             w_raw_norm;
    logic             w_differs;
    logic             w_toggle;
    logic             w_press_evt;
    logic             w_rel_evt;
    logic             w_tmr_zero;
    rpt_state_t       w_state_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_repeat_nxt;

    assign w_raw_norm  = (ACTIVE_LOW != 0) ? ~i_raw : i_raw;
    assign w_differs   = r_sync2 ^ r_stable;
    assign w_toggle    = w_differs && (r_cnt == CNT_LAST);
    assign w_press_evt = w_toggle & ~r_stable;
    assign w_rel_evt   = w_toggle & r_stable;
    assign w_tmr_zero  = (r_timer == '0);

    // Synchronise the raw level and accept a new stable level after enough differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_stable  <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= w_raw_norm;
            r_sync2   <= r_sync1;
            r_press   <= w_press_evt;
            r_release <= w_rel_evt;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_toggle) begin
                r_cnt    <= '0;
                r_stable <= ~r_stable;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Repeat FSM state register, with the timer and repeat pulse it drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_repeat <= w_repeat_nxt;
        end
    end

    // Next-state: a release always wins, so no repeat can coincide with it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_press_evt) w_state_nxt = ST_DELAY;
            end
            ST_DELAY: begin
                if (w_rel_evt)                              w_state_nxt = ST_IDLE;
                else if ((REPEAT_EN != 0) && w_tmr_zero)    w_state_nxt = ST_REPEAT;
            end
            ST_REPEAT: begin
                if (w_rel_evt) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: down-counting timer, reloaded on terminal count, repeat pulse at terminal count.
    always_comb begin
        w_repeat_nxt = 1'b0;
        w_timer_nxt  = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (w_press_evt) w_timer_nxt = DELAY_LOAD;
            end
            ST_DELAY, ST_REPEAT: begin
                if (w_rel_evt) begin
                    w_timer_nxt = '0;
                end else if ((REPEAT_EN != 0) && w_tmr_zero) begin
                    w_repeat_nxt = 1'b1;
                    w_timer_nxt  = PERIOD_LOAD;
                end else if (!w_tmr_zero) begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: w_timer_nxt = '0;
        endcase
    end

    assign o_level      = r_stable;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_repeat     = r_repeat;
    assign o_press_nxt  = w_press_evt;
    assign o_repeat_nxt = w_repeat_nxt;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: per-channel debounce/repeat plus a registered event encoder.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_BTN-1:0]                         buttons_i,
    output logic [NUM_BTN-1:0]                         btn_level_o,
    output logic [NUM_BTN-1:0]                         btn_press_o,
    output logic [NUM_BTN-1:0]                         btn_release_o,
    output logic [NUM_BTN-1:0]                         btn_repeat_o,
    output logic                                       evt_valid_o,
    output logic [max2(1, clog2(NUM_BTN))-1:0]         evt_code_o,
    output logic                                       evt_multi_o
);

    localparam int CODE_W = max2(1, clog2(NUM_BTN));

    logic [NUM_BTN-1:0] w_press_nxt;
    logic [NUM_BTN-1:0] w_repeat_nxt;
    logic [NUM_BTN-1:0] w_evt_bits;
    logic [CODE_W-1:0]  w_code;
    logic               w_multi;

    logic               r_evt_valid;
    logic [CODE_W-1:0]  r_evt_code;
    logic               r_evt_multi;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        btn_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .i_raw        (buttons_i[g]),
            .o_level      (btn_level_o[g]),
            .o_press      (btn_press_o[g]),
            .o_release    (btn_release_o[g]),
            .o_repeat     (btn_repeat_o[g]),
            .o_press_nxt  (w_press_nxt[g]),
            .o_repeat_nxt (w_repeat_nxt[g])
        );
    end

    // Encode the events the channels are about to register; releases are deliberately excluded.
    always_comb begin
        w_evt_bits = w_press_nxt | w_repeat_nxt;
        w_code     = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_evt_bits[i]) w_code = CODE_W'(i);
        end
        w_multi = |(w_evt_bits & (w_evt_bits - NUM_BTN'(1)));
    end

    // Register the encoder so it lines up with the per-channel pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_valid <= 1'b0;
            r_evt_code  <= '0;
            r_evt_multi <= 1'b0;
        end else begin
            r_evt_valid <= |w_evt_bits;
            r_evt_code  <= w_code;
            r_evt_multi <= w_multi;
        end
    end

    assign evt_valid_o = r_evt_valid;
    assign evt_code_o  = r_evt_code;
    assign evt_multi_o = r_evt_multi;

endmodule
